// File: rtl/uart_pkg.sv
// Shared types and constants for the UART message transmitter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_NUM_BYTES    = 12;
  localparam logic IDLE_LEVEL     = 1'b1;
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, wraps, and flags the last cycle of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (restart) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_msg_tx.sv
// Serialises an NUM_BYTES-character message as back-to-back 8N1 frames, first character first.
// Optional UART_MSG_AUTO_SEND_EN: a message change seen in IDLE starts a transmission like send.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int NUM_BYTES    = DEF_NUM_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] msg_in,
  input  logic                   send,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t                 state;
  logic [8*NUM_BYTES-1:0] msg_reg;
  logic [BW-1:0]          byte_idx;
  logic [2:0]             bit_idx;
  logic [7:0]             cur_byte;
  logic                   tick;
  logic                   go;
  int                     sel;

  // Timer is held at zero while idle so the start bit always gets a full period.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .tick    (tick)
  );

`ifdef UART_MSG_AUTO_SEND_EN
  logic [8*NUM_BYTES-1:0] last_sent;
  assign go = send || (msg_in != last_sent);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      last_sent <= '0;
    else if (state == IDLE && go) last_sent <= msg_in;
  end
`else
  assign go = send;
`endif

  always_comb begin
    sel      = NUM_BYTES - 1 - int'(byte_idx);
    cur_byte = msg_reg[8*sel +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= IDLE_LEVEL;
      busy     <= 1'b0;
      done     <= 1'b0;
      msg_reg  <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= IDLE_LEVEL;
          busy <= 1'b0;
          if (go) begin
            msg_reg  <= msg_in;
            byte_idx <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: if (tick) begin
          bit_idx <= '0;
          tx      <= cur_byte[0];
          state   <= DATA;
        end
        DATA: if (tick) begin
          if (bit_idx == 3'd7) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= cur_byte[bit_idx + 3'd1];
          end
        end
        STOP: if (tick) begin
          if (byte_idx != BW'(NUM_BYTES - 1)) begin
            byte_idx <= byte_idx + 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end else begin
            tx    <= IDLE_LEVEL;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
